// File: rtl/rf_pkg.sv
// Shared constants and the buffered-write record for the register-file
// write arbiter.
//   AW   : register address width
//   DW   : register data width
//   NREG : number of architectural registers (width of the pending mask)
package rf_pkg;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  // One buffered secondary write; valid drops when a primary write supersedes it.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/wr_fifo.sv
// In-order buffer for secondary register-file writes.
//   clk, reset     : clock, synchronous active-high reset
//   push_i         : enqueue {push_addr_i, push_data_i} at the tail
//   pop_i          : retire the head entry
//   inv_i          : clear valid on every entry whose addr == inv_addr_i
//   head_o         : head entry (valid=0 when empty or superseded)
//   count_o        : occupied slots, including superseded entries
//   pend_mask_o    : one bit per register with a valid buffered write
module wr_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [AW-1:0]          push_addr_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  input  logic                   inv_i,
  input  logic [AW-1:0]          inv_addr_i,
  output rf_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [NREG-1:0]        pend_mask_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rf_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^PW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage: invalidate, retire and fill never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (inv_i && mem_q[i].valid && (mem_q[i].addr == inv_addr_i))
          mem_q[i].valid <= 1'b0;
      end
      if (pop_i)  mem_q[rd_ptr_q].valid <= 1'b0;
      if (push_i) mem_q[wr_ptr_q] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pending-write reduction; x0 is never reported.
  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_q[i].valid) pend_mask_o[mem_q[i].addr] = 1'b1;
    end
    pend_mask_o[0] = 1'b0;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the writeback path (primary,
// never back-pressured) and a long-latency unit (secondary, valid/ready).
//   clk, reset            : clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data : primary write
//   ex_valid/ex_ready     : secondary handshake; ex_addr/ex_data payload
//   we3/a3/wd3            : register-file write port (combinational)
//   pend_mask             : registers with a buffered write still pending
//   stall_req             : asks the core to hold wb_we low next cycle
//   count                 : buffered entries
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STARVE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DW-1:0]          wb_data,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [AW-1:0]          ex_addr,
  input  logic [DW-1:0]          ex_data,
  output logic                   we3,
  output logic [AW-1:0]          a3,
  output logic [DW-1:0]          wd3,
  output logic [NREG-1:0]        pend_mask,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned AGW = $clog2(STARVE) + 1;

  rf_entry_t       head;
  logic [CW-1:0]   fifo_count;
  logic [NREG-1:0] fifo_mask;
  logic            prim, nonempty, pop, bypass, push, blocked;
  logic [AGW-1:0]  age_q, age_d;
  logic            stall_q, stall_d;

  assign prim     = wb_we && (wb_addr != '0);
  assign nonempty = (fifo_count != '0);
  assign ex_ready = !reset && (fifo_count < CW'(DEPTH));
  assign pop      = !reset && !prim && nonempty;
  assign bypass   = !reset && !prim && !nonempty && ex_valid && (ex_addr != '0);
  // x0 writes and writes superseded by a same-cycle primary are acked but dropped.
  assign push     = ex_valid && ex_ready && !bypass && (ex_addr != '0)
                    && !(prim && (ex_addr == wb_addr));
  assign blocked  = prim && nonempty && head.valid;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_addr_i (ex_addr),
    .push_data_i (ex_data),
    .pop_i       (pop),
    .inv_i       (prim && !reset),
    .inv_addr_i  (wb_addr),
    .head_o      (head),
    .count_o     (fifo_count),
    .pend_mask_o (fifo_mask)
  );

  // Write-port mux: primary, then buffer head, then bypass.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (!reset) begin
      if (prim) begin
        we3 = 1'b1;
        a3  = wb_addr;
        wd3 = wb_data;
      end else if (nonempty) begin
        // A superseded head retires silently.
        if (head.valid) begin
          we3 = 1'b1;
          a3  = head.addr;
          wd3 = head.data;
        end
      end else if (bypass) begin
        we3 = 1'b1;
        a3  = ex_addr;
        wd3 = ex_data;
      end
    end
  end

  // Starvation age of the head; saturates once the stall threshold is reached.
  always_comb begin
    age_d   = age_q;
    stall_d = blocked && (age_q >= AGW'(STARVE - 1));
    if (!nonempty || pop)                         age_d = '0;
    else if (blocked && (age_q < AGW'(STARVE - 1))) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req = stall_q && !reset;
  assign pend_mask = reset ? '0 : fifo_mask;
  assign count     = reset ? '0 : fifo_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rf_write_arbiter;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned STARVE = 4;

  logic                   clk;
  logic                   reset;
  logic                   wb_we;
  logic [AW-1:0]          wb_addr;
  logic [DW-1:0]          wb_data;
  logic                   ex_valid;
  logic                   ex_ready;
  logic [AW-1:0]          ex_addr;
  logic [DW-1:0]          ex_data;
  logic                   we3;
  logic [AW-1:0]          a3;
  logic [DW-1:0]          wd3;
  logic [NREG-1:0]        pend_mask;
  logic                   stall_req;
  logic [$clog2(DEPTH):0] count;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_mask (pend_mask),
    .stall_req (stall_req),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: buffered writes in acceptance order, plus head age.
  typedef struct {
    bit v;
    int a;
    int d;
  } ent_t;
  ent_t q[$];
  int   age     = 0;
  bit   m_stall = 0;

  // Outputs derived from the model state and present inputs.
  always @(negedge clk) begin
    bit              p, e_we, e_rdy;
    int              e_a, e_d;
    logic [NREG-1:0] e_pend;
    if (chk_en) begin
      p = wb_we && (wb_addr != 0);
      e_we = 0; e_a = 0; e_d = 0; e_rdy = 0; e_pend = '0;
      if (!reset) begin
        e_rdy = (q.size() < DEPTH);
        foreach (q[i]) if (q[i].v) e_pend[q[i].a] = 1'b1;
        e_pend[0] = 1'b0;
        if (p) begin
          e_we = 1; e_a = wb_addr; e_d = wb_data;
        end else if (q.size() > 0) begin
          if (q[0].v) begin e_we = 1; e_a = q[0].a; e_d = q[0].d; end
        end else if (ex_valid && ex_addr != 0) begin
          e_we = 1; e_a = ex_addr; e_d = ex_data;
        end
      end
      check("we3", 64'(we3), 64'(e_we));
      check("a3", 64'(a3), 64'(e_a));
      check("wd3", 64'(wd3), 64'(e_d));
      check("ex_ready", 64'(ex_ready), 64'(e_rdy));
      check("pend_mask", 64'(pend_mask), 64'(e_pend));
      check("count", 64'(count), reset ? 64'd0 : 64'(q.size()));
      check("stall_req", 64'(stall_req), reset ? 64'd0 : 64'(m_stall));
      check("no_x0_write", 64'(we3 && a3 == 0), 64'd0);
    end
  end

  // Model state advance on each active edge.
  always @(posedge clk) begin
    int sz;
    bit p, pop, blk, byp, acc;
    if (reset) begin
      q.delete();
      age     = 0;
      m_stall = 0;
      chk_en  = 1;
    end else begin
      sz  = q.size();
      p   = wb_we && (wb_addr != 0);
      pop = !p && sz > 0;
      blk = p && sz > 0 && q[0].v;
      byp = !p && sz == 0 && ex_valid && ex_addr != 0;
      acc = ex_valid && sz < DEPTH;
      m_stall = blk && (age >= STARVE - 1);
      if (pop || sz == 0) age = 0;
      else if (blk)       age++;
      if (p) foreach (q[i]) if (q[i].a == wb_addr) q[i].v = 0;
      if (pop) void'(q.pop_front());
      if (acc && !byp && ex_addr != 0 && !(p && ex_addr == wb_addr))
        q.push_back('{v: 1, a: ex_addr, d: ex_data});
    end
  end

  task automatic drv(input bit we, input int wa, input int wd,
                     input bit ev, input int ea, input int ed);
    wb_we    = we;
    wb_addr  = AW'(wa);
    wb_data  = DW'(wd);
    ex_valid = ev;
    ex_addr  = AW'(ea);
    ex_data  = DW'(ed);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick;
    mid;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(ex_ready), 64'd0);
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    tick;
    reset = 1'b0;

    // Primary write, zero latency.
    drv(1, 5, 'hAA, 0, 0, 0);
    mid;
    check("prim_we3", 64'(we3), 64'd1);
    check("prim_a3", 64'(a3), 64'd5);
    check("prim_wd3", 64'(wd3), 64'hAA);
    check("prim_count", 64'(count), 64'd0);
    tick;

    // Bypass with empty buffer.
    drv(0, 0, 0, 1, 7, 'h11);
    mid;
    check("byp_a3", 64'(a3), 64'd7);
    check("byp_wd3", 64'(wd3), 64'h11);
    check("byp_ready", 64'(ex_ready), 64'd1);
    check("byp_pend", 64'(pend_mask), 64'd0);
    tick;

    // Primary busy three cycles while the secondary offers 3, 4, 6.
    drv(1, 10, 1, 1, 3, 'h33);
    mid;
    check("buf_cnt0", 64'(count), 64'd0);
    tick;
    drv(1, 11, 2, 1, 4, 'h44);
    tick;
    drv(1, 12, 3, 1, 6, 'h66);
    mid;
    check("buf_cnt2", 64'(count), 64'd2);
    check("buf_full_ready", 64'(ex_ready), 64'd0);
    check("buf_pend", 64'(pend_mask), 64'h18);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    mid;
    check("drain0_a3", 64'(a3), 64'd3);
    check("drain0_wd3", 64'(wd3), 64'h33);
    tick;
    mid;
    check("drain1_a3", 64'(a3), 64'd4);
    check("drain1_wd3", 64'(wd3), 64'h44);
    tick;
    drv(0, 0, 0, 1, 6, 'h66);
    mid;
    check("drain2_byp_a3", 64'(a3), 64'd6);
    check("drain2_count", 64'(count), 64'd0);
    tick;

    // Primary supersedes a buffered write to x9.
    drv(1, 20, 2, 1, 9, 'h99);
    tick;
    drv(1, 9, 'h55, 0, 0, 0);
    mid;
    check("sup_wd3", 64'(wd3), 64'h55);
    check("sup_pend_before", 64'(pend_mask), 64'h200);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    mid;
    check("sup_pend_after", 64'(pend_mask), 64'd0);
    check("sup_dead_pop_we3", 64'(we3), 64'd0);
    check("sup_count", 64'(count), 64'd1);
    tick;
    mid;
    check("sup_count_after", 64'(count), 64'd0);
    tick;

    // Starvation: head x13 blocked by a held primary.
    drv(1, 21, 7, 1, 13, 'hD);
    tick;
    drv(1, 22, 8, 0, 0, 0);
    n = 0;
    mid;
    while (!stall_req && n < 10) begin
      tick;
      n++;
      mid;
    end
    check("starve_blocked_cycles", 64'(n), 64'd4);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    mid;
    check("starve_head_a3", 64'(a3), 64'd13);
    check("starve_stall_hold", 64'(stall_req), 64'd1);
    tick;
    mid;
    check("starve_stall_drop", 64'(stall_req), 64'd0);
    check("starve_count", 64'(count), 64'd0);
    tick;

    // Secondary write to x0 under a busy primary: acked, dropped.
    drv(1, 23, 9, 1, 0, 'hEE);
    mid;
    check("x0_ready", 64'(ex_ready), 64'd1);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    mid;
    check("x0_count", 64'(count), 64'd0);
    tick;

    // Reset with two buffered entries.
    drv(1, 24, 1, 1, 14, 'h14);
    tick;
    drv(1, 25, 2, 1, 15, 'h15);
    tick;
    drv(1, 26, 3, 0, 0, 0);
    mid;
    check("prerst_count", 64'(count), 64'd2);
    check("prerst_pend", 64'(pend_mask), 64'hC000);
    tick;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    mid;
    check("midrst_pend", 64'(pend_mask), 64'd0);
    check("midrst_we3", 64'(we3), 64'd0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid;
      check("postrst_we3", 64'(we3), 64'd0);
      check("postrst_count", 64'(count), 64'd0);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
